// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add (MULT/MULTU) or restoring
// subtract-shift (DIV/DIVU) step per cycle. Define MULDIV_ABORT_EN to add an abort input.
module muldiv_unit #(
    parameter int WIDTH             = 32,
    parameter bit SIGNED_EN_DEFAULT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             is_div, neg_q, neg_r, dz_pend;

    logic             sgn_op, a_neg, b_neg, b_zero_div;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign busy = (state == RUN);

    // Operand decode: the datapath only ever sees magnitudes.
    always_comb begin
        sgn_op     = SIGNED_EN_DEFAULT && !op[0];
        a_neg      = sgn_op && a[WIDTH-1];
        b_neg      = sgn_op && b[WIDTH-1];
        a_mag      = a_neg ? -a : a;
        b_mag      = b_neg ? -b : b;
        b_zero_div = op[1] && (b == '0);
    end

    // One iteration step for each operation, plus final sign correction.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        // When the trial succeeds the difference is below the divisor, so W bits suffice.
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        prod_fix  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix   = neg_q ? -acc_lo : acc_lo;
        rem_fix   = neg_r ? -acc_hi : acc_hi;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = b_zero_div ? FINISH : RUN;
            RUN: begin
                if (count == CW'(1)) state_nxt = FINISH;
`ifdef MULDIV_ABORT_EN
                if (abort) state_nxt = IDLE;
`endif
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_pend  <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    count   <= CW'(WIDTH);
                    acc_hi  <= '0;
                    acc_lo  <= a_mag;
                    opnd    <= b_mag;
                    is_div  <= op[1];
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    dz_pend <= b_zero_div;
                end
                RUN: begin
                    count <= count - CW'(1);
                    if (is_div) begin
                        if (div_ge) begin
                            acc_hi <= div_diff;
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    done     <= 1'b1;
                    div_zero <= dz_pend;
                    // A divide by zero leaves the previous result visible.
                    if (!dz_pend) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
`ifdef MULDIV_ABORT_EN
    logic         abort;
`endif

    int   errors = 0;
    int   checks = 0;
    int   lat, bcnt, seen;
    logic hold_ok;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .SIGNED_EN_DEFAULT(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef MULDIV_ABORT_EN
        .abort(abort),
`endif
        .op(op), .a(a), .b(b), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge inside the done cycle.
    // inject_at >= 0 pulses a DIVU-by-zero start while the op is running.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int inject_at);
        logic [W-1:0] h0, l0;
        h0 = hi; l0 = lo; hold_ok = 1'b1;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
            if (lat == inject_at) begin
                start = 1'b1; op = 2'b11; a = 32'h1; b = 32'h0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
`ifdef MULDIV_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'b00, 32'hFFFFFFFD, 32'd7, -1);
        chk("mult_lat", lat, 33);
        chk("mult_busy_cycles", bcnt, 32);
        chk("mult_hold", hold_ok, 1);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);
        chk("mult_dz", div_zero, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        chk("multu_prod", {hi, lo}, 64'hFFFFFFFE_00000001);
        // next start lands in the done cycle and must be accepted
        run_op(2'b11, 32'd100, 32'd7, -1);
        chk("b2b_lat", lat, 33);
        chk("divu_lo", lo, 14);
        chk("divu_hi", hi, 2);
        @(negedge clk);

        run_op(2'b11, 32'd100, 32'd0, -1);
        chk("dz_lat", lat, 1);
        chk("dz_busy", bcnt, 0);
        chk("dz_flag", div_zero, 1);
        chk("dz_hi", hi, 2);
        chk("dz_lo", lo, 14);
        repeat (3) @(negedge clk);
        chk("dz_flag_hold", div_zero, 1);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, -1);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);
        chk("div_dz_clear", div_zero, 0);
        @(negedge clk);

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, -1);
        chk("div_min_lo", lo, 32'h80000000);
        chk("div_min_hi", hi, 0);
        chk("div_min_dz", div_zero, 0);
        @(negedge clk);

        run_op(2'b10, 32'd7, 32'hFFFFFFFE, -1);
        chk("div_negb_lo", lo, 32'hFFFFFFFD);
        chk("div_negb_hi", hi, 1);
        @(negedge clk);

        run_op(2'b00, 32'd5, 32'hFFFFFFFD, 4);
        chk("busy_start_lat", lat, 33);
        chk("busy_start_prod", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        chk("busy_start_dz", div_zero, 0);
        @(negedge clk);
        chk("busy_start_idle", busy, 0);

        run_op(2'b01, 32'h12345678, 32'h100, -1);
        chk("multu_shift", {hi, lo}, 64'h00000012_34567800);
        @(negedge clk);

        run_op(2'b11, 32'hFFFFFFFF, 32'h10, -1);
        chk("divu_big_lo", lo, 32'h0FFFFFFF);
        chk("divu_big_hi", hi, 32'hF);
        @(negedge clk);

        run_op(2'b00, 32'h80000000, 32'h80000000, -1);
        chk("mult_min_sq", {hi, lo}, 64'h40000000_00000000);
        @(negedge clk);

        // start sampled on the edge done rises must be ignored
        op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        op = 2'b11; a = 32'd1; b = 32'd0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("edge_done", done, 1);
        chk("edge_lo", lo, 9);
        @(negedge clk);
        chk("edge_ignored_busy", busy, 0);
        chk("edge_ignored_done", done, 0);
        chk("edge_ignored_dz", div_zero, 0);

        // reset ten cycles into a multiply
        op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_hi", hi, 0);
        chk("mid_rst_lo", lo, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("mid_rst_no_done", seen, 0);

        run_op(2'b00, 32'd6, 32'd7, -1);
        chk("post_rst_lat", lat, 33);
        chk("post_rst_prod", {hi, lo}, 64'd42);
        @(negedge clk);

`ifdef MULDIV_ABORT_EN
        op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_hold", {hi, lo}, 64'd42);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
